// File: rtl/sync_fifo_param_if.sv
//------------------------------------------------------------------------------
// sync_fifo_param_if
//
// Handshake and status bundle between a single-clock FIFO and the logic
// around it.
//
// Modports:
//   master : producer/consumer side. Drives wr_en, wdata, rd_en (and err_clr)
//            and observes data plus status.
//   slave  : FIFO side. Mirror image of master.
//
// Signals:
//   wr_en, wdata                    write request and data
//   rd_en                           read request
//   rdata, rvalid                   registered read data and its strobe
//   full, empty                     occupancy extremes
//   almost_full, almost_empty       threshold flags
//   count                           fill level, 0..2**ADDRESS_SIZE
//   overflow, underflow, err_clr    sticky error flags and their clear;
//                                   present only when FIFO_ERR_FLAGS_EN
//                                   is defined
//------------------------------------------------------------------------------
interface sync_fifo_param_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDRESS_SIZE = 4
);
    logic                    wr_en;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    rd_en;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rvalid;
    logic                    full;
    logic                    empty;
    logic                    almost_full;
    logic                    almost_empty;
    logic [ADDRESS_SIZE:0]   count;
`ifdef FIFO_ERR_FLAGS_EN
    logic                    overflow;
    logic                    underflow;
    logic                    err_clr;

    modport master (
        output wr_en, wdata, rd_en, err_clr,
        input  rdata, rvalid, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );

    modport slave (
        input  wr_en, wdata, rd_en, err_clr,
        output rdata, rvalid, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );
`else
    modport master (
        output wr_en, wdata, rd_en,
        input  rdata, rvalid, full, empty, almost_full, almost_empty, count
    );

    modport slave (
        input  wr_en, wdata, rd_en,
        output rdata, rvalid, full, empty, almost_full, almost_empty, count
    );
`endif
endinterface

// File: rtl/sync_fifo_param.sv
//------------------------------------------------------------------------------
// sync_fifo_param
//
// Parametrised single-clock FIFO. Holds 2**ADDRESS_SIZE words of DATA_WIDTH
// bits, uses extra-bit read/write pointers to tell full from empty, reports
// the fill level and almost-full/almost-empty thresholds, and returns read
// data through a register with a one-cycle rvalid strobe.
//
// Ports:
//   clk    : clock, all state updates on the rising edge
//   rst_n  : asynchronous active-low reset
//   fifo   : sync_fifo_param_if.slave
//              wr_en/wdata   write request, accepted when not full
//              rd_en         read request, accepted when not empty
//              rdata/rvalid  read data, updated on the accepting edge;
//                            rvalid is high for the cycle after that edge
//              full/empty/almost_full/almost_empty/count  status
//              overflow/underflow/err_clr  sticky error flags (optional)
//
// Build option:
//   FIFO_ERR_FLAGS_EN  when defined, adds sticky overflow/underflow flags
//                      cleared by err_clr. When undefined, rejected requests
//                      are silently ignored.
//------------------------------------------------------------------------------
module sync_fifo_param #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_SIZE  = 4,
    parameter int AFULL_THRESH  = 14,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    sync_fifo_param_if.slave fifo
);

    localparam int DEPTH = 2 ** ADDRESS_SIZE;
    localparam logic [ADDRESS_SIZE:0] AFULL_LVL  = (ADDRESS_SIZE+1)'(AFULL_THRESH);
    localparam logic [ADDRESS_SIZE:0] AEMPTY_LVL = (ADDRESS_SIZE+1)'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [ADDRESS_SIZE:0]   w_ptr;
    logic [ADDRESS_SIZE:0]   r_ptr;
    logic [ADDRESS_SIZE:0]   level;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    rvalid_q;
    logic                    full_w;
    logic                    empty_w;
    logic                    wr_accept;
    logic                    rd_accept;

    // Status is a pure function of the registered pointers, so no request
    // input reaches a flag combinationally.
    assign empty_w = (w_ptr == r_ptr);
    assign full_w  = (w_ptr[ADDRESS_SIZE-1:0] == r_ptr[ADDRESS_SIZE-1:0]) &&
                     (w_ptr[ADDRESS_SIZE] != r_ptr[ADDRESS_SIZE]);
    // Modular subtraction gives the true level even after pointer wrap.
    assign level   = w_ptr - r_ptr;

    assign wr_accept = fifo.wr_en && !full_w;
    assign rd_accept = fifo.rd_en && !empty_w;

    // Pointer stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr <= '0;
            r_ptr <= '0;
        end else begin
            if (wr_accept) w_ptr <= w_ptr + 1'b1;
            if (rd_accept) r_ptr <= r_ptr + 1'b1;
        end
    end

    // Storage stage; contents are not reset, the pointers alone define what
    // is valid.
    always_ff @(posedge clk) begin
        if (wr_accept) mem[w_ptr[ADDRESS_SIZE-1:0]] <= fifo.wdata;
    end

    // Read register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd_accept;
            if (rd_accept) rdata_q <= mem[r_ptr[ADDRESS_SIZE-1:0]];
        end
    end

    assign fifo.rdata        = rdata_q;
    assign fifo.rvalid       = rvalid_q;
    assign fifo.full         = full_w;
    assign fifo.empty        = empty_w;
    assign fifo.count        = level;
    assign fifo.almost_full  = (level >= AFULL_LVL);
    assign fifo.almost_empty = (level <= AEMPTY_LVL);

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    // Sticky error stage; a new error on the clearing edge takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (fifo.wr_en && full_w)  overflow_q  <= 1'b1;
            else if (fifo.err_clr)     overflow_q  <= 1'b0;
            if (fifo.rd_en && empty_w) underflow_q <= 1'b1;
            else if (fifo.err_clr)     underflow_q <= 1'b0;
        end
    end

    assign fifo.overflow  = overflow_q;
    assign fifo.underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
//------------------------------------------------------------------------------
// tb_sync_fifo_param
//
// Directed self-checking bench for sync_fifo_param with default parameters
// (8-bit data, depth 16, thresholds 14/2). Covers reset, fill, drain,
// steady-state streaming through pointer wrap, simultaneous requests at the
// full and empty boundaries, optional error flags, and asynchronous reset
// mid-stream.
//------------------------------------------------------------------------------
module tb_sync_fifo_param;

    localparam int DW = 8;
    localparam int AS = 4;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    sync_fifo_param_if #(.DATA_WIDTH(DW), .ADDRESS_SIZE(AS)) bus ();

    sync_fifo_param #(
        .DATA_WIDTH   (DW),
        .ADDRESS_SIZE (AS),
        .AFULL_THRESH (14),
        .AEMPTY_THRESH(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .fifo (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.wdata = '0;
`ifdef FIFO_ERR_FLAGS_EN
        bus.err_clr = 1'b0;
`endif
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle_inputs();

        // Reset state
        #12;
        chk("rst_empty",  32'(bus.empty), 32'd1);
        chk("rst_full",   32'(bus.full), 32'd0);
        chk("rst_count",  32'(bus.count), 32'd0);
        chk("rst_afull",  32'(bus.almost_full), 32'd0);
        chk("rst_aempty", 32'(bus.almost_empty), 32'd1);
        chk("rst_rdata",  32'(bus.rdata), 32'd0);
        chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        chk("rst_udf", 32'(bus.underflow), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Fill with 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            bus.wr_en = 1'b1;
            bus.wdata = 8'(i);
            step();
            chk("fill_count",  32'(bus.count), 32'(i + 1));
            chk("fill_full",   32'(bus.full), (i == 15) ? 32'd1 : 32'd0);
            chk("fill_afull",  32'(bus.almost_full), (i + 1 >= 14) ? 32'd1 : 32'd0);
            chk("fill_aempty", 32'(bus.almost_empty), (i + 1 <= 2) ? 32'd1 : 32'd0);
            chk("fill_empty",  32'(bus.empty), 32'd0);
            chk("fill_rvalid", 32'(bus.rvalid), 32'd0);
        end
        bus.wr_en = 1'b0;

        // Drain in order
        for (int i = 0; i < 16; i++) begin
            bus.rd_en = 1'b1;
            step();
            chk("drain_rdata",  32'(bus.rdata), 32'(i));
            chk("drain_rvalid", 32'(bus.rvalid), 32'd1);
            chk("drain_count",  32'(bus.count), 32'(15 - i));
            chk("drain_empty",  32'(bus.empty), (i == 15) ? 32'd1 : 32'd0);
            chk("drain_aempty", 32'(bus.almost_empty), (15 - i <= 2) ? 32'd1 : 32'd0);
            chk("drain_full",   32'(bus.full), 32'd0);
        end
        bus.rd_en = 1'b0;
        step();
        chk("idle_rvalid", 32'(bus.rvalid), 32'd0);
        chk("idle_rdata_hold", 32'(bus.rdata), 32'h0F);

        // Stream at level 8 through pointer wrap
        for (int i = 0; i < 8; i++) begin
            bus.wr_en = 1'b1;
            bus.wdata = 8'(8'h20 + i);
            step();
        end
        chk("stream_pre_count", 32'(bus.count), 32'd8);
        for (int k = 0; k < 40; k++) begin
            bus.wr_en = 1'b1;
            bus.rd_en = 1'b1;
            bus.wdata = 8'(8'h28 + k);
            step();
            chk("stream_rdata",  32'(bus.rdata), 32'(8'h20 + k));
            chk("stream_rvalid", 32'(bus.rvalid), 32'd1);
            chk("stream_count",  32'(bus.count), 32'd8);
            chk("stream_full",   32'(bus.full), 32'd0);
            chk("stream_empty",  32'(bus.empty), 32'd0);
        end
        bus.wr_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.rd_en = 1'b1;
            step();
            chk("stream_tail", 32'(bus.rdata), 32'(8'h48 + i));
        end
        bus.rd_en = 1'b0;
        chk("stream_end_empty", 32'(bus.empty), 32'd1);

        // Simultaneous requests while full: write dropped
        for (int i = 0; i < 16; i++) begin
            bus.wr_en = 1'b1;
            bus.wdata = 8'(8'h50 + i);
            step();
        end
        chk("both_pre_full", 32'(bus.full), 32'd1);
        bus.wr_en = 1'b1;
        bus.rd_en = 1'b1;
        bus.wdata = 8'hEE;
        step();
        chk("both_full_count",  32'(bus.count), 32'd15);
        chk("both_full_rdata",  32'(bus.rdata), 32'h50);
        chk("both_full_rvalid", 32'(bus.rvalid), 32'd1);
        chk("both_full_flag",   32'(bus.full), 32'd0);
        bus.wr_en = 1'b0;
        for (int i = 1; i < 16; i++) begin
            step();
            chk("after_full_rdata", 32'(bus.rdata), 32'(8'h50 + i));
        end
        bus.rd_en = 1'b0;
        chk("after_full_empty", 32'(bus.empty), 32'd1);

        // Simultaneous requests while empty: read rejected
        bus.wr_en = 1'b1;
        bus.rd_en = 1'b1;
        bus.wdata = 8'h77;
        step();
        chk("both_empty_count",  32'(bus.count), 32'd1);
        chk("both_empty_rvalid", 32'(bus.rvalid), 32'd0);
        chk("both_empty_rdata",  32'(bus.rdata), 32'h5F);
        bus.wr_en = 1'b0;
        step();
        chk("both_empty_read", 32'(bus.rdata), 32'h77);
        chk("both_empty_rv2",  32'(bus.rvalid), 32'd1);
        bus.rd_en = 1'b0;

`ifdef FIFO_ERR_FLAGS_EN
        // Sticky error flags
        bus.rd_en = 1'b1;
        step();
        chk("udf_set", 32'(bus.underflow), 32'd1);
        chk("udf_ovf", 32'(bus.overflow), 32'd0);
        bus.rd_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.wr_en = 1'b1;
            bus.wdata = 8'(8'hA0 + i);
            step();
        end
        chk("ovf_before", 32'(bus.overflow), 32'd0);
        step();
        chk("ovf_set", 32'(bus.overflow), 32'd1);
        chk("ovf_count", 32'(bus.count), 32'd16);
        bus.wr_en = 1'b0;
        step();
        chk("ovf_hold", 32'(bus.overflow), 32'd1);
        chk("udf_hold", 32'(bus.underflow), 32'd1);
        bus.err_clr = 1'b1;
        step();
        chk("clr_ovf", 32'(bus.overflow), 32'd0);
        chk("clr_udf", 32'(bus.underflow), 32'd0);
        bus.wr_en = 1'b1;
        step();
        chk("clr_vs_set", 32'(bus.overflow), 32'd1);
        bus.wr_en = 1'b0;
        step();
        chk("clr_again", 32'(bus.overflow), 32'd0);
        bus.err_clr = 1'b0;
`endif

        // Asynchronous reset mid-stream
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.wr_en = 1'b1;
            bus.wdata = 8'(8'h90 + i);
            step();
        end
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b1;
        step();
        chk("pre_arst_rdata", 32'(bus.rdata), 32'h90);
        chk("pre_arst_count", 32'(bus.count), 32'd4);
        bus.rd_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_empty",  32'(bus.empty), 32'd1);
        chk("arst_count",  32'(bus.count), 32'd0);
        chk("arst_rdata",  32'(bus.rdata), 32'd0);
        chk("arst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("arst_aempty", 32'(bus.almost_empty), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_arst_empty", 32'(bus.empty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
